mm_tile_seq: RTL and testbench

MM_TILE_SEQ -- requirements
Module: mm_tile_seq

---
 rtl/mm_pkg.sv | 45 ++++
 rtl/mm_tile_seq_if.sv | 47 ++++
 rtl/mm_tile_geom.sv | 36 +++
 rtl/mm_tile_seq.sv | 219 +++++++++++++++++++++
 tb/tb_mm_tile_seq.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mm_pkg : shared FSM state type, parameter defaults and sizing helpers   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package mm_pkg;

  localparam int TILE_DEF  = 4;
  localparam int DIM_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD_W = 2'd1,
    ST_RUN    = 2'd2,
    ST_FIN    = 2'd3
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Index width covers the largest tile index of a full-scale dimension
  function automatic int cnt_width(input int tile, input int dim_w);
    int c;
    c = clog2(ceil_div((1 << dim_w) - 1, tile));
    return (c < 1) ? 1 : c;
  endfunction

  function automatic int val_width(input int tile);
    return clog2(tile + 1);
  endfunction

  function automatic int sh_width(input int tile);
    return clog2((tile - 1) * 8 + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mm_tile_seq_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mm_tile_seq_if : request/control bundle of the tile sequencer            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface mm_tile_seq_if #(
  parameter int TILE  = mm_pkg::TILE_DEF,
  parameter int DIM_W = mm_pkg::DIM_W_DEF
);
  localparam int CNT_W = mm_pkg::cnt_width(TILE, DIM_W);
  localparam int VAL_W = mm_pkg::val_width(TILE);
  localparam int SH_W  = mm_pkg::sh_width(TILE);

  logic                 start;
  logic [3*DIM_W-1:0]   mnt;
  logic                 tile_done;
  logic                 load;
  logic                 start_calc;
  logic                 calc_pulse;
  logic                 acc_clr;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [CNT_W-1:0]     wrow;
  logic [CNT_W-1:0]     icol;
  logic [CNT_W-1:0]     ndep;
  logic [2*CNT_W-1:0]   odst;
  logic [VAL_W-1:0]     val_m;
  logic [VAL_W-1:0]     val_n;
  logic [VAL_W-1:0]     val_t;
  logic [SH_W-1:0]      sh_i;
  logic [SH_W-1:0]      sh_w;

  modport master (
    output start, mnt, tile_done,
    input  load, start_calc, calc_pulse, acc_clr, busy, done, err,
    input  wrow, icol, ndep, odst, val_m, val_n, val_t, sh_i, sh_w
  );

  modport slave (
    input  start, mnt, tile_done,
    output load, start_calc, calc_pulse, acc_clr, busy, done, err,
    output wrow, icol, ndep, odst, val_m, val_n, val_t, sh_i, sh_w
  );

endinterface
`default_nettype wire

// File: rtl/mm_tile_geom.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mm_tile_geom : valid extent and pad shift of one tile along a dimension |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mm_tile_geom
  import mm_pkg::*;
#(
  parameter int TILE  = TILE_DEF,
  parameter int DIM_W = DIM_W_DEF
) (
  input  logic [DIM_W-1:0]                  dim,
  input  logic [cnt_width(TILE, DIM_W)-1:0] idx,
  output logic [val_width(TILE)-1:0]        val,
  output logic [sh_width(TILE)-1:0]         sh
);
  localparam int VAL_W = val_width(TILE);
  localparam int SH_W  = sh_width(TILE);
  // Wide enough for dim - idx*TILE and for the TILE constant itself
  localparam int CW    = (DIM_W + 1 > VAL_W) ? DIM_W + 1 : VAL_W;

  logic [CW-1:0] w_base;
  logic [CW-1:0] w_rem;
  logic [CW-1:0] w_val;

  always_comb begin
    w_base = CW'(idx) * CW'(TILE);
    w_rem  = CW'(dim) - w_base;
    w_val  = (w_rem > CW'(TILE)) ? CW'(TILE) : w_rem;
  end

  assign val = VAL_W'(w_val);
  assign sh  = SH_W'((TILE - int'(w_val)) * 8);

endmodule
`default_nettype wire

// File: rtl/mm_tile_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mm_tile_seq : walks the m/t/n tile loop of a tiled matrix multiply       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mm_tile_seq
  import mm_pkg::*;
#(
  parameter int TILE  = TILE_DEF,
  parameter int DIM_W = DIM_W_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  mm_tile_seq_if.slave  bus
);
  localparam int CNT_W = cnt_width(TILE, DIM_W);
  localparam int VAL_W = val_width(TILE);
  localparam int SH_W  = sh_width(TILE);
  localparam int OD_W  = 2 * CNT_W;

  state_t r_state;
  state_t w_state_nxt;

  logic [DIM_W-1:0] r_dim_m, r_dim_n, r_dim_t;
  logic [CNT_W-1:0] r_last_m, r_last_n, r_last_t;
  logic [CNT_W-1:0] r_m, r_n, r_t;
  logic [OD_W-1:0]  r_odst;
  logic [VAL_W-1:0] r_val_m, r_val_n, r_val_t;
  logic [SH_W-1:0]  r_sh_i, r_sh_w;
  logic             r_calc_pulse;
  logic             r_err;

  logic [DIM_W-1:0] w_in_m, w_in_n, w_in_t;
  logic [CNT_W-1:0] w_in_last_m, w_in_last_n, w_in_last_t;
  logic [DIM_W-1:0] w_dim_m, w_dim_n, w_dim_t;
  logic [CNT_W-1:0] w_last_t_src;
  logic [CNT_W-1:0] w_nxt_m, w_nxt_n, w_nxt_t;
  logic [OD_W-1:0]  w_odst_nxt;
  logic [VAL_W-1:0] w_val_m, w_val_n, w_val_t;
  logic [SH_W-1:0]  w_sh_m, w_sh_n, w_sh_t;
  logic             w_unused_sh_t;
  logic             w_dims_ok, w_start_ok, w_adv, w_last_pass, w_need_load, w_upd;
  logic             w_load, w_start_calc, w_acc_clr, w_busy, w_done;

  assign w_in_m = bus.mnt[3*DIM_W-1 -: DIM_W];
  assign w_in_n = bus.mnt[2*DIM_W-1 -: DIM_W];
  assign w_in_t = bus.mnt[DIM_W-1:0];

  // Last tile index = ceil(dim/TILE) - 1, which always fits the index width
  assign w_in_last_m = CNT_W'((int'(w_in_m) - 1) / TILE);
  assign w_in_last_n = CNT_W'((int'(w_in_n) - 1) / TILE);
  assign w_in_last_t = CNT_W'((int'(w_in_t) - 1) / TILE);

  assign w_dims_ok   = (w_in_m != '0) && (w_in_n != '0) && (w_in_t != '0);
  assign w_start_ok  = (r_state == ST_IDLE) && bus.start && w_dims_ok;
  assign w_adv       = (r_state == ST_RUN) && bus.tile_done;
  assign w_last_pass = (r_m == r_last_m) && (r_t == r_last_t) && (r_n == r_last_n);

  // Depth innermost, then output column, then output row
  always_comb begin
    w_nxt_m = r_m;
    w_nxt_n = r_n;
    w_nxt_t = r_t;
    if (w_start_ok) begin
      w_nxt_m = '0;
      w_nxt_n = '0;
      w_nxt_t = '0;
    end else if (r_n != r_last_n) begin
      w_nxt_n = r_n + 1'b1;
    end else begin
      w_nxt_n = '0;
      if (r_t != r_last_t) begin
        w_nxt_t = r_t + 1'b1;
      end else begin
        w_nxt_t = '0;
        w_nxt_m = r_m + 1'b1;
      end
    end
  end

  assign w_need_load = (w_nxt_m != r_m) || (w_nxt_n != r_n);
  assign w_upd       = w_start_ok || (w_adv && !w_last_pass);

  // The accepting cycle sees the new dimensions before they are latched
  assign w_dim_m      = w_start_ok ? w_in_m      : r_dim_m;
  assign w_dim_n      = w_start_ok ? w_in_n      : r_dim_n;
  assign w_dim_t      = w_start_ok ? w_in_t      : r_dim_t;
  assign w_last_t_src = w_start_ok ? w_in_last_t : r_last_t;
  assign w_odst_nxt   = OD_W'(w_nxt_m) * (OD_W'(w_last_t_src) + OD_W'(1)) + OD_W'(w_nxt_t);

  mm_tile_geom #(.TILE(TILE), .DIM_W(DIM_W)) u_geom_m (
    .dim (w_dim_m),
    .idx (w_nxt_m),
    .val (w_val_m),
    .sh  (w_sh_m)
  );

  mm_tile_geom #(.TILE(TILE), .DIM_W(DIM_W)) u_geom_n (
    .dim (w_dim_n),
    .idx (w_nxt_n),
    .val (w_val_n),
    .sh  (w_sh_n)
  );

  mm_tile_geom #(.TILE(TILE), .DIM_W(DIM_W)) u_geom_t (
    .dim (w_dim_t),
    .idx (w_nxt_t),
    .val (w_val_t),
    .sh  (w_sh_t)
  );

  assign w_unused_sh_t = ^w_sh_t;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_start_ok) w_state_nxt = ST_LOAD_W;
      ST_LOAD_W: w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (bus.tile_done) begin
          if (w_last_pass)      w_state_nxt = ST_FIN;
          else if (w_need_load) w_state_nxt = ST_LOAD_W;
          else                  w_state_nxt = ST_RUN;
        end
      end
      ST_FIN:    w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_load       = 1'b0;
    w_start_calc = 1'b0;
    w_done       = 1'b0;
    w_busy       = (r_state != ST_IDLE);
    w_acc_clr    = 1'b0;
    case (r_state)
      ST_LOAD_W: w_load = 1'b1;
      ST_RUN: begin
        w_start_calc = 1'b1;
        w_acc_clr    = (r_n == '0);
      end
      ST_FIN:    w_done = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dim_m      <= '0;
      r_dim_n      <= '0;
      r_dim_t      <= '0;
      r_last_m     <= '0;
      r_last_n     <= '0;
      r_last_t     <= '0;
      r_m          <= '0;
      r_n          <= '0;
      r_t          <= '0;
      r_odst       <= '0;
      r_val_m      <= '0;
      r_val_n      <= '0;
      r_val_t      <= '0;
      r_sh_i       <= '0;
      r_sh_w       <= '0;
      r_calc_pulse <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_err        <= (r_state == ST_IDLE) && bus.start && !w_dims_ok;
      // First RUN cycle: after a weight load, or straight on with the same weights
      r_calc_pulse <= (r_state == ST_LOAD_W) || (w_adv && !w_last_pass && !w_need_load);
      if (w_start_ok) begin
        r_dim_m  <= w_in_m;
        r_dim_n  <= w_in_n;
        r_dim_t  <= w_in_t;
        r_last_m <= w_in_last_m;
        r_last_n <= w_in_last_n;
        r_last_t <= w_in_last_t;
      end
      if (w_upd) begin
        r_m     <= w_nxt_m;
        r_n     <= w_nxt_n;
        r_t     <= w_nxt_t;
        r_odst  <= w_odst_nxt;
        r_val_m <= w_val_m;
        r_val_n <= w_val_n;
        r_val_t <= w_val_t;
        r_sh_i  <= w_sh_n;
        r_sh_w  <= w_sh_m;
      end
    end
  end

  assign bus.load       = w_load;
  assign bus.start_calc = w_start_calc;
  assign bus.calc_pulse = r_calc_pulse;
  assign bus.acc_clr    = w_acc_clr;
  assign bus.busy       = w_busy;
  assign bus.done       = w_done;
  assign bus.err        = r_err;
  assign bus.wrow       = r_m;
  assign bus.icol       = r_t;
  assign bus.ndep       = r_n;
  assign bus.odst       = r_odst;
  assign bus.val_m      = r_val_m;
  assign bus.val_n      = r_val_n;
  assign bus.val_t      = r_val_t;
  assign bus.sh_i       = r_sh_i;
  assign bus.sh_w       = r_sh_w;

endmodule
`default_nettype wire

// File: tb/tb_mm_tile_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mm_tile_seq : directed self-checking bench, TILE=4 DIM_W=4            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_mm_tile_seq;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mm_tile_seq_if #(.TILE(4), .DIM_W(4)) bus ();

  mm_tile_seq #(.TILE(4), .DIM_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] obs_odst [8];
  logic       obs_acc  [8];
  logic       obs_sc   [8];
  logic       obs_calc2[8];
  logic [2:0] obs_vm   [8];
  logic [2:0] obs_vn   [8];
  logic [2:0] obs_vt   [8];
  logic [4:0] obs_shi  [8];
  logic [4:0] obs_shw  [8];
  int         obs_loads;
  int         obs_dones;
  int         obs_timeouts;
  logic       obs_busy_end;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation of npass passes and records what each pass showed
  task automatic drive_op(input logic [3:0] m, input logic [3:0] n, input logic [3:0] t,
                          input int npass);
    bit found;
    obs_loads    = 0;
    obs_dones    = 0;
    obs_timeouts = 0;
    bus.mnt   = {m, n, t};
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int p = 0; p < npass; p++) begin
      found = 1'b0;
      for (int k = 0; k < 3 && !found; k++) begin
        if (bus.load) obs_loads++;
        if (bus.calc_pulse) found = 1'b1;
        else step();
      end
      if (!found) obs_timeouts++;
      obs_odst[p] = bus.odst;
      obs_acc[p]  = bus.acc_clr;
      obs_sc[p]   = bus.start_calc;
      obs_vm[p]   = bus.val_m;
      obs_vn[p]   = bus.val_n;
      obs_vt[p]   = bus.val_t;
      obs_shi[p]  = bus.sh_i;
      obs_shw[p]  = bus.sh_w;
      step();
      obs_calc2[p] = bus.calc_pulse;
      bus.tile_done = 1'b1;
      step();
      bus.tile_done = 1'b0;
      if (bus.done) obs_dones++;
    end
    step();
    obs_busy_end = bus.busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.tile_done = 1'b0;
    bus.mnt = '0;
    #12;
    checks++;
    if ({bus.load, bus.start_calc, bus.calc_pulse, bus.acc_clr, bus.busy, bus.done, bus.err,
         bus.wrow, bus.icol, bus.ndep, bus.odst, bus.val_m, bus.val_n, bus.val_t,
         bus.sh_i, bus.sh_w} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%0b odst=%0d val_m=%0d sh_w=%0d required all 0",
               bus.busy, bus.odst, bus.val_m, bus.sh_w);
    end
    #2 rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    bus.mnt = {4'd4, 4'd4, 4'd4};
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    checks++;
    if ({bus.load, bus.busy, bus.calc_pulse, bus.start_calc} !== 4'b1100) begin
      errors++;
      $display("FAIL single_load_cycle got load/busy/calc/sc=%b required 1100",
               {bus.load, bus.busy, bus.calc_pulse, bus.start_calc});
    end
    step();
    checks++;
    if ({bus.load, bus.calc_pulse, bus.start_calc, bus.acc_clr} !== 4'b0111) begin
      errors++;
      $display("FAIL single_run_cycle got load/calc/sc/acc=%b required 0111",
               {bus.load, bus.calc_pulse, bus.start_calc, bus.acc_clr});
    end
    checks++;
    if ({bus.odst, bus.sh_i, bus.sh_w, bus.val_m, bus.val_n, bus.val_t} !== {4'd0, 5'd0, 5'd0, 3'd4, 3'd4, 3'd4}) begin
      errors++;
      $display("FAIL single_geom got odst=%0d shi=%0d shw=%0d vm=%0d required 0 0 0 4",
               bus.odst, bus.sh_i, bus.sh_w, bus.val_m);
    end
    bus.tile_done = 1'b1;
    step();
    bus.tile_done = 1'b0;
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL single_done got %0b required 1", bus.done);
    end
    step();
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      errors++;
      $display("FAIL single_idle got busy/done=%b required 00", {bus.busy, bus.done});
    end
  endtask

  task automatic test_multi();
    logic [3:0] e_odst [8] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3};
    logic [2:0] e_vm   [8] = '{3'd4, 3'd4, 3'd4, 3'd4, 3'd1, 3'd1, 3'd1, 3'd1};
    logic [2:0] e_vn   [8] = '{3'd4, 3'd2, 3'd4, 3'd2, 3'd4, 3'd2, 3'd4, 3'd2};
    logic [2:0] e_vt   [8] = '{3'd4, 3'd4, 3'd3, 3'd3, 3'd4, 3'd4, 3'd3, 3'd3};
    logic [4:0] e_shi, e_shw;
    drive_op(4'd5, 4'd6, 4'd7, 8);
    checks++;
    if (obs_loads !== 8 || obs_timeouts !== 0) begin
      errors++;
      $display("FAIL multi_loads got %0d (timeouts %0d) required 8 (0)", obs_loads, obs_timeouts);
    end
    checks++;
    if (obs_dones !== 1 || obs_busy_end !== 1'b0) begin
      errors++;
      $display("FAIL multi_done got dones=%0d busy=%0b required 1 0", obs_dones, obs_busy_end);
    end
    for (int p = 0; p < 8; p++) begin
      e_shi = (e_vn[p] == 3'd4) ? 5'd0 : 5'd16;
      e_shw = (e_vm[p] == 3'd4) ? 5'd0 : 5'd24;
      checks++;
      if (obs_odst[p] !== e_odst[p]) begin
        errors++;
        $display("FAIL multi_odst[%0d] got %0d required %0d", p, obs_odst[p], e_odst[p]);
      end
      checks++;
      if (obs_acc[p] !== ((p % 2) == 0) || obs_sc[p] !== 1'b1 || obs_calc2[p] !== 1'b0) begin
        errors++;
        $display("FAIL multi_ctrl[%0d] got acc=%0b sc=%0b calc2=%0b required %0b 1 0",
                 p, obs_acc[p], obs_sc[p], obs_calc2[p], (p % 2) == 0);
      end
      checks++;
      if ({obs_vm[p], obs_vn[p], obs_vt[p], obs_shi[p], obs_shw[p]} !==
          {e_vm[p], e_vn[p], e_vt[p], e_shi, e_shw}) begin
        errors++;
        $display("FAIL multi_geom[%0d] got vm=%0d vn=%0d vt=%0d shi=%0d shw=%0d required %0d %0d %0d %0d %0d",
                 p, obs_vm[p], obs_vn[p], obs_vt[p], obs_shi[p], obs_shw[p],
                 e_vm[p], e_vn[p], e_vt[p], e_shi, e_shw);
      end
    end
  endtask

  task automatic test_same_weight();
    logic [2:0] e_vt [3] = '{3'd4, 3'd4, 3'd1};
    drive_op(4'd3, 4'd2, 4'd9, 3);
    checks++;
    if (obs_loads !== 1 || obs_timeouts !== 0 || obs_dones !== 1) begin
      errors++;
      $display("FAIL same_w_loads got loads=%0d timeouts=%0d dones=%0d required 1 0 1",
               obs_loads, obs_timeouts, obs_dones);
    end
    for (int p = 0; p < 3; p++) begin
      checks++;
      if ({obs_odst[p], obs_vt[p], obs_vm[p], obs_vn[p], obs_shi[p], obs_shw[p]} !==
          {4'(p), e_vt[p], 3'd3, 3'd2, 5'd16, 5'd8}) begin
        errors++;
        $display("FAIL same_w_pass[%0d] got odst=%0d vt=%0d vm=%0d vn=%0d shi=%0d shw=%0d required %0d %0d 3 2 16 8",
                 p, obs_odst[p], obs_vt[p], obs_vm[p], obs_vn[p], obs_shi[p], obs_shw[p], p, e_vt[p]);
      end
    end
  endtask

  task automatic test_err_ignore();
    bus.mnt = {4'd4, 4'd0, 4'd4};
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    checks++;
    if ({bus.err, bus.busy, bus.load} !== 3'b100) begin
      errors++;
      $display("FAIL err_pulse got err/busy/load=%b required 100", {bus.err, bus.busy, bus.load});
    end
    step();
    checks++;
    if ({bus.err, bus.busy, bus.icol, bus.val_t, bus.val_m} !== {1'b0, 1'b0, 2'd2, 3'd1, 3'd3}) begin
      errors++;
      $display("FAIL err_hold got err=%0b busy=%0b icol=%0d vt=%0d vm=%0d required 0 0 2 1 3",
               bus.err, bus.busy, bus.icol, bus.val_t, bus.val_m);
    end
    bus.mnt = {4'd4, 4'd4, 4'd8};
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    bus.mnt = {4'd2, 4'd2, 4'd2};
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    checks++;
    if ({bus.wrow, bus.icol, bus.ndep, bus.start_calc, bus.load, bus.err, bus.val_t} !==
        {2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd4}) begin
      errors++;
      $display("FAIL run_start_ignored got icol=%0d sc=%0b load=%0b err=%0b vt=%0d required 0 1 0 0 4",
               bus.icol, bus.start_calc, bus.load, bus.err, bus.val_t);
    end
    bus.tile_done = 1'b1;
    step();
    bus.tile_done = 1'b0;
    checks++;
    if ({bus.calc_pulse, bus.load, bus.icol, bus.odst, bus.val_t} !== {1'b1, 1'b0, 2'd1, 4'd1, 3'd4}) begin
      errors++;
      $display("FAIL run_second_pass got calc=%0b load=%0b icol=%0d odst=%0d vt=%0d required 1 0 1 1 4",
               bus.calc_pulse, bus.load, bus.icol, bus.odst, bus.val_t);
    end
    bus.tile_done = 1'b1;
    step();
    bus.tile_done = 1'b0;
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL run_done got %0b required 1", bus.done);
    end
    step();
  endtask

  task automatic test_start_on_last();
    bus.mnt = {4'd4, 4'd4, 4'd4};
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    bus.tile_done = 1'b1;
    bus.start = 1'b1;
    step();
    bus.tile_done = 1'b0;
    bus.start = 1'b0;
    checks++;
    if ({bus.done, bus.load} !== 2'b10) begin
      errors++;
      $display("FAIL coinc_done got done/load=%b required 10", {bus.done, bus.load});
    end
    step();
    checks++;
    if ({bus.busy, bus.done, bus.load} !== 3'b000) begin
      errors++;
      $display("FAIL coinc_idle got busy/done/load=%b required 000", {bus.busy, bus.done, bus.load});
    end
    step();
    checks++;
    if ({bus.busy, bus.load, bus.calc_pulse} !== 3'b000) begin
      errors++;
      $display("FAIL coinc_no_new_op got busy/load/calc=%b required 000",
               {bus.busy, bus.load, bus.calc_pulse});
    end
  endtask

  task automatic test_reset_mid();
    bus.mnt = {4'd5, 4'd6, 4'd7};
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    bus.tile_done = 1'b1;
    step();
    bus.tile_done = 1'b0;
    step();
    checks++;
    if ({bus.ndep, bus.val_n, bus.sh_i, bus.start_calc} !== {2'd1, 3'd2, 5'd16, 1'b1}) begin
      errors++;
      $display("FAIL midrst_pre got ndep=%0d vn=%0d shi=%0d sc=%0b required 1 2 16 1",
               bus.ndep, bus.val_n, bus.sh_i, bus.start_calc);
    end
    #2 rst_n = 1'b0;
    step();
    checks++;
    if ({bus.load, bus.start_calc, bus.calc_pulse, bus.acc_clr, bus.busy, bus.done, bus.err,
         bus.wrow, bus.icol, bus.ndep, bus.odst, bus.val_m, bus.val_n, bus.val_t,
         bus.sh_i, bus.sh_w} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs got busy=%0b done=%0b ndep=%0d vn=%0d shi=%0d required all 0",
               bus.busy, bus.done, bus.ndep, bus.val_n, bus.sh_i);
    end
    #3 rst_n = 1'b1;
    step();
    drive_op(4'd4, 4'd4, 4'd4, 1);
    checks++;
    if (obs_loads !== 1 || obs_dones !== 1 || obs_timeouts !== 0 || obs_busy_end !== 1'b0) begin
      errors++;
      $display("FAIL midrst_restart got loads=%0d dones=%0d timeouts=%0d busy=%0b required 1 1 0 0",
               obs_loads, obs_dones, obs_timeouts, obs_busy_end);
    end
    checks++;
    if ({obs_odst[0], obs_acc[0], obs_vm[0], obs_vn[0], obs_vt[0], obs_shi[0], obs_shw[0]} !==
        {4'd0, 1'b1, 3'd4, 3'd4, 3'd4, 5'd0, 5'd0}) begin
      errors++;
      $display("FAIL midrst_geom got odst=%0d acc=%0b vn=%0d shi=%0d required 0 1 4 0",
               obs_odst[0], obs_acc[0], obs_vn[0], obs_shi[0]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_multi();
    test_same_weight();
    test_err_ignore();
    test_start_on_last();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
